// File: rtl/flash_seq_pkg.sv
// -----------------------------------------------------------------------------
// flash_seq_pkg
// Shared definitions for the flash array sequencer: command opcode encodings,
// the sequencer state enum and a small integer helper used to size the
// operation timer.
// -----------------------------------------------------------------------------
package flash_seq_pkg;

  // Command opcodes as presented on cmd_op
  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARM,
    ST_EQ,
    ST_SENSE,
    ST_PROG,
    ST_ERASE,
    ST_FIN
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flash_seq_timer.sv
// -----------------------------------------------------------------------------
// flash_seq_timer
// Loadable down-counter shared by all timed sequencer states. The count is
// loaded with (duration - 1) when a state is entered and the owning state
// exits on the cycle the zero flag is high.
//
// Ports:
//   sck      : clock, rising edge
//   rst      : synchronous reset, active-high (count cleared to 0)
//   load     : load load_val on the next edge (takes priority over counting)
//   load_val : value to load
//   zero     : count is zero
// -----------------------------------------------------------------------------
module flash_seq_timer #(
  parameter int W = 7
) (
  input  logic         sck,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Saturates at zero so an idle timer stays parked with zero asserted
  always_ff @(posedge sck) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/flash_mem_sequencer.sv
// -----------------------------------------------------------------------------
// flash_mem_sequencer
// Drives the analog flash array control pins for single READ, PROGRAM and
// ERASE commands. One timed state machine handles analog warm-up, bit-line
// equalisation, sensing and the fixed program/erase strobe durations, and
// captures the read line.
//
// Optional build macro: FLASH_PROG_VERIFY_EN
//   When defined, every PROGRAM is followed by a warm EQ + SENSE readback; the
//   byte lane mem_addr[3:0] is compared with the programmed byte and prog_err
//   pulses with done on mismatch. When undefined prog_err is tied low.
//
// Ports:
//   sck, rst              : clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake, ready only in IDLE
//   cmd_op/addr/wdata     : opcode, target address, program byte
//   rd_data/rd_valid      : captured read line and its one-cycle update pulse
//   done/cmd_err/prog_err : end-of-command pulse and its error qualifiers
//   busy                  : high from the cycle after accept through done
//   mem_data              : array read line
//   analog_on/eq/en_wr/erase : array control pins
//   mem_addr/mem_data_in  : address and program byte latched at accept
// -----------------------------------------------------------------------------
module flash_mem_sequencer
  import flash_seq_pkg::*;
#(
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 8,
  parameter int LINE_W     = 128,
  parameter int T_WARM     = 4,
  parameter int T_EQ       = 2,
  parameter int T_READ     = 3,
  parameter int T_PROG     = 16,
  parameter int T_ERASE    = 64,
  parameter int T_IDLE_OFF = 8
) (
  input  logic              sck,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [LINE_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              cmd_err,
  output logic              prog_err,
  output logic              busy,
  input  logic [LINE_W-1:0] mem_data,
  output logic              analog_on,
  output logic              eq,
  output logic              en_wr,
  output logic              erase,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in
);

  localparam int T_MAX = max_int(max_int(max_int(T_WARM, T_EQ), max_int(T_READ, T_PROG)),
                                 max_int(T_ERASE, T_IDLE_OFF));
  localparam int TW    = $clog2(T_MAX + 1);
  localparam int IW    = $clog2(T_IDLE_OFF + 1);

  state_t          state;
  state_t          state_next;
  logic [1:0]      op_q;
  logic [IW-1:0]   idle_cnt;
  logic            accept;
  logic            idle_hit;
  logic            cold;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_zero;
  logic            sense_end;
  logic            verify_phase;

  assign accept    = cmd_valid && (state == ST_IDLE);
  // The idle counter is about to reach the power-down threshold this cycle.
  // An accept here is treated as cold: the supply is considered to have timed
  // out, so the full warm-up is run even though analog_on is still high.
  assign idle_hit  = (idle_cnt == IW'(T_IDLE_OFF - 1));
  assign cold      = !analog_on || idle_hit;
  assign sense_end = (state == ST_SENSE) && tmr_zero;

  flash_seq_timer #(.W(TW)) u_timer (
    .sck      (sck),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // State register
  always_ff @(posedge sck) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, timer loads and pin decode. Timer is loaded with T-1 on the
  // transition into each timed state so the state lasts exactly T cycles.
  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    eq         = 1'b0;
    en_wr      = 1'b0;
    erase      = 1'b0;
    done       = 1'b0;
    rd_valid   = 1'b0;
    cmd_err    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (accept) begin
          if (cmd_op == OP_RSVD) begin
            state_next = ST_FIN;
          end else if (cold) begin
            state_next = ST_WARM;
            tmr_load   = 1'b1;
            tmr_val    = TW'(T_WARM - 1);
          end else begin
            state_next = ST_EQ;
            tmr_load   = 1'b1;
            tmr_val    = TW'(T_EQ - 1);
          end
        end
      end
      ST_WARM: begin
        if (tmr_zero) begin
          state_next = ST_EQ;
          tmr_load   = 1'b1;
          tmr_val    = TW'(T_EQ - 1);
        end
      end
      ST_EQ: begin
        eq = 1'b1;
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (verify_phase || op_q == OP_READ) begin
            state_next = ST_SENSE;
            tmr_val    = TW'(T_READ - 1);
          end else if (op_q == OP_PROG) begin
            state_next = ST_PROG;
            tmr_val    = TW'(T_PROG - 1);
          end else begin
            state_next = ST_ERASE;
            tmr_val    = TW'(T_ERASE - 1);
          end
        end
      end
      ST_SENSE: begin
        if (tmr_zero) begin
          state_next = ST_FIN;
        end
      end
      ST_PROG: begin
        en_wr = 1'b1;
        if (tmr_zero) begin
`ifdef FLASH_PROG_VERIFY_EN
          state_next = ST_EQ;
          tmr_load   = 1'b1;
          tmr_val    = TW'(T_EQ - 1);
`else
          state_next = ST_FIN;
`endif
        end
      end
      ST_ERASE: begin
        erase = 1'b1;
        if (tmr_zero) begin
          state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        done       = 1'b1;
        rd_valid   = (op_q == OP_READ);
        cmd_err    = (op_q == OP_RSVD);
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Command latches, idle power-down counter, analog supply and read capture.
  // The idle counter only advances in IDLE without an accept and saturates at
  // the threshold; it is cleared by every accept and holds while busy.
  always_ff @(posedge sck) begin
    if (rst) begin
      op_q        <= OP_READ;
      mem_addr    <= '0;
      mem_data_in <= '0;
      idle_cnt    <= '0;
      analog_on   <= 1'b0;
      rd_data     <= '0;
    end else begin
      if (accept) begin
        op_q        <= cmd_op;
        mem_addr    <= cmd_addr;
        mem_data_in <= cmd_wdata;
        idle_cnt    <= '0;
        if (cmd_op != OP_RSVD) begin
          analog_on <= 1'b1;
        end else if (idle_hit) begin
          analog_on <= 1'b0;
        end
      end else if (state == ST_IDLE && idle_cnt != IW'(T_IDLE_OFF)) begin
        idle_cnt <= idle_cnt + 1'b1;
        if (idle_hit) begin
          analog_on <= 1'b0;
        end
      end
      if (sense_end && !verify_phase) begin
        rd_data <= mem_data;
      end
    end
  end

`ifdef FLASH_PROG_VERIFY_EN
  logic              verify_fail;
  logic [DATA_W-1:0] verify_lane;

  assign verify_lane = mem_data[int'(mem_addr[3:0]) * DATA_W +: DATA_W];

  // verify_phase marks the readback EQ/SENSE pass that follows a program
  always_ff @(posedge sck) begin
    if (rst) begin
      verify_phase <= 1'b0;
      verify_fail  <= 1'b0;
    end else begin
      if (accept) begin
        verify_phase <= 1'b0;
        verify_fail  <= 1'b0;
      end else if (state == ST_PROG && tmr_zero) begin
        verify_phase <= 1'b1;
      end
      if (sense_end && verify_phase) begin
        verify_fail <= (verify_lane != mem_data_in);
      end
    end
  end

  assign prog_err = (state == ST_FIN) && verify_fail;
`else
  assign verify_phase = 1'b0;
  assign prog_err     = 1'b0;
`endif

endmodule
